bpred_resolve: RTL and testbench

Execute-side resolution stage for the bimodal/BTB branch predictor. Holds per-fetch prediction metadata in a small in-order queue while instructions travel from fetch to execute. Compares each prediction with the resolved outcome at execute and drives the predictor update port (`execute_bpredictor_*`, `up_btb_data`, `up_carry_data`, `byte_en`). Raises a one-cycle redirect and flushes wrong-path entries on a mispredict.

---
 rtl/bpred_resolve_if.sv | 53 +++++
 rtl/bpred_resolve.sv | 138 +++++++++++++
 tb/tb_bpred_resolve.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpred_resolve_if.sv
// Fetch-push, execute-resolve, predictor-update and redirect signals of the resolve stage.
// Pure wiring bundle: no state, no latency of its own.
// fetch_ready / execute_ready are the only backpressure signals; update and redirect outputs are never stalled.
interface bpred_resolve_if;
  // fetch push side
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_PC4;
  logic        fetch_p_dir;
  logic [31:0] fetch_p_target;
  logic [11:0] fetch_bimodal;
  logic [8:0]  fetch_carry;
  // execute resolve side
  logic        execute_valid;
  logic        execute_ready;
  logic        execute_is_branch;
  logic        execute_taken;
  logic [31:0] execute_target;
  logic        soin_bpredictor_stall;
  // predictor update port
  logic        execute_bpredictor_update;
  logic [31:0] execute_bpredictor_PC4;
  logic [31:0] execute_bpredictor_target;
  logic        execute_bpredictor_dir;
  logic        execute_bpredictor_miss;
  logic [11:0] execute_bpredictor_bimodal;
  logic [29:0] up_btb_data;
  logic [8:0]  up_carry_data;
  logic [3:0]  byte_en;
  // front-end redirect
  logic        resolve_flush;
  logic [31:0] resolve_redirect_PC;

  // master: the pipeline/environment driving fetch and execute
  modport master (
    output fetch_valid, fetch_PC4, fetch_p_dir, fetch_p_target, fetch_bimodal, fetch_carry,
    output execute_valid, execute_is_branch, execute_taken, execute_target, soin_bpredictor_stall,
    input  fetch_ready, execute_ready,
    input  execute_bpredictor_update, execute_bpredictor_PC4, execute_bpredictor_target,
    input  execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_bimodal,
    input  up_btb_data, up_carry_data, byte_en, resolve_flush, resolve_redirect_PC
  );

  // slave: the resolve stage itself
  modport slave (
    input  fetch_valid, fetch_PC4, fetch_p_dir, fetch_p_target, fetch_bimodal, fetch_carry,
    input  execute_valid, execute_is_branch, execute_taken, execute_target, soin_bpredictor_stall,
    output fetch_ready, execute_ready,
    output execute_bpredictor_update, execute_bpredictor_PC4, execute_bpredictor_target,
    output execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_bimodal,
    output up_btb_data, up_carry_data, byte_en, resolve_flush, resolve_redirect_PC
  );
endinterface

// File: rtl/bpred_resolve.sv
// Holds fetch-time prediction metadata in order, resolves it at execute and drives predictor update/redirect.
// Update and redirect outputs are registered: valid the cycle after the pop edge.
// fetch_ready drops when the queue is full; execute_ready drops when empty or an update is held by predictor stall.
module bpred_resolve #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  bpred_resolve_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic        p_dir;
    logic [31:0] p_target;
    logic [11:0] bimodal;
    logic [8:0]  carry;
  } entry_t;

  entry_t      r_mem [DEPTH];
  logic [AW:0] r_rd;
  logic [AW:0] r_wr;

  logic        r_pend;
  logic        r_miss;
  logic        r_dir;
  logic [31:0] r_pc4;
  logic [31:0] r_tgt;
  logic [11:0] r_bim;
  logic [8:0]  r_carry;
  logic [3:0]  r_be;
  logic        r_flush;
  logic [31:0] r_redir;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_br_pop;
  logic        w_miss;
  logic        w_mispredict;
  logic [AW:0] w_rd_nxt;
  entry_t      w_head;
  entry_t      w_new;

  // Queue status, handshakes and comparison of the head prediction with the resolved outcome
  always_comb begin
    w_full       = (r_rd[AW-1:0] == r_wr[AW-1:0]) && (r_rd[AW] != r_wr[AW]);
    w_empty      = (r_rd == r_wr);
    w_head       = r_mem[r_rd[AW-1:0]];
    w_new        = '{pc4: bus.fetch_PC4, p_dir: bus.fetch_p_dir, p_target: bus.fetch_p_target,
                     bimodal: bus.fetch_bimodal, carry: bus.fetch_carry};
    w_push       = bus.fetch_valid && !w_full;
    // a held update blocks further resolution so it cannot be overwritten before the predictor takes it
    w_pop        = bus.execute_valid && !w_empty && !(r_pend && bus.soin_bpredictor_stall);
    w_br_pop     = w_pop && bus.execute_is_branch;
    w_miss       = (w_head.p_dir != bus.execute_taken) ||
                   (bus.execute_taken && w_head.p_dir && (w_head.p_target != bus.execute_target));
    w_mispredict = w_br_pop && w_miss;
    w_rd_nxt     = w_pop ? r_rd + (AW+1)'(1) : r_rd;
  end

  // Read/write pointers; a mispredict discards everything younger than the resolved entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_rd <= w_rd_nxt;
      if (w_mispredict) begin
        r_wr <= w_rd_nxt;
      end else if (w_push) begin
        r_wr <= r_wr + (AW+1)'(1);
      end
    end
  end

  // Entry storage; a push coinciding with a mispredict is wrong-path and is dropped
  always_ff @(posedge clk) begin
    if (!reset && w_push && !w_mispredict) begin
      r_mem[r_wr[AW-1:0]] <= w_new;
    end
  end

  // Predictor update register: loaded by a branch pop, held until the predictor is not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= 1'b0;
      r_miss  <= 1'b0;
      r_dir   <= 1'b0;
      r_pc4   <= '0;
      r_tgt   <= '0;
      r_bim   <= '0;
      r_carry <= '0;
      r_be    <= 4'b0000;
    end else if (w_br_pop) begin
      r_pend  <= 1'b1;
      r_miss  <= w_miss;
      r_dir   <= bus.execute_taken;
      r_pc4   <= w_head.pc4;
      r_tgt   <= bus.execute_target;
      r_bim   <= w_head.bimodal;
      r_carry <= w_head.carry;
      // taken branches also refresh the BTB entry
      r_be    <= bus.execute_taken ? 4'b1111 : 4'b0001;
    end else if (!bus.soin_bpredictor_stall) begin
      r_pend  <= 1'b0;
    end
  end

  // One-cycle flush pulse and the corrected fetch PC on a mispredict
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush <= 1'b0;
      r_redir <= '0;
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict) begin
        r_redir <= bus.execute_taken ? bus.execute_target : w_head.pc4;
      end
    end
  end

  assign bus.fetch_ready                = !w_full;
  assign bus.execute_ready              = !w_empty && !(r_pend && bus.soin_bpredictor_stall);
  assign bus.execute_bpredictor_update  = r_pend;
  assign bus.execute_bpredictor_PC4     = r_pc4;
  assign bus.execute_bpredictor_target  = r_tgt;
  assign bus.execute_bpredictor_dir     = r_dir;
  assign bus.execute_bpredictor_miss    = r_miss;
  assign bus.execute_bpredictor_bimodal = r_bim;
  assign bus.up_btb_data                = r_tgt[31:2];
  assign bus.up_carry_data              = r_carry;
  assign bus.byte_en                    = r_be;
  assign bus.resolve_flush              = r_flush;
  assign bus.resolve_redirect_PC        = r_redir;
endmodule

// File: tb/tb_bpred_resolve.sv
// Bench for bpred_resolve: directed vector table, corner-case sequences and random traffic vs a queue model.
// Outputs are compared #1 after the rising edge; ready signals are compared before the edge.
// Backpressure is exercised through full queue, empty queue and predictor stall.
module tb_bpred_resolve;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bpred_resolve_if bus();

  bpred_resolve #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    bit          fv;
    logic [31:0] pc4;
    bit          pdir;
    logic [31:0] ptgt;
    logic [11:0] bim;
    logic [8:0]  carry;
    bit          ev;
    bit          br;
    bit          tk;
    logic [31:0] tgt;
    bit          stall;
    bit          rst;
  } stim_t;

  typedef struct {
    logic [31:0] pc4;
    bit          pdir;
    logic [31:0] ptgt;
    logic [11:0] bim;
    logic [8:0]  carry;
  } ent_t;

  typedef struct {
    logic [31:0] pc4;
    bit          pdir;
    logic [31:0] ptgt;
    logic [11:0] bim;
    bit          tk;
    logic [31:0] tgt;
    bit          x_miss;
    bit          x_dir;
    logic [3:0]  x_be;
    bit          x_flush;
    logic [31:0] x_redir;
    logic [29:0] x_btb;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  ent_t        mq[$];
  bit          m_pend, m_flush, m_miss, m_dir, m_zero;
  logic [31:0] m_pc4, m_tgt, m_redir;
  logic [11:0] m_bim;
  logic [8:0]  m_carry;
  logic [3:0]  m_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t mk_push(input logic [31:0] pc4, input bit pdir, input logic [31:0] ptgt,
                                    input logic [11:0] bim, input logic [8:0] carry);
    stim_t s;
    s = idle();
    s.fv = 1'b1; s.pc4 = pc4; s.pdir = pdir; s.ptgt = ptgt; s.bim = bim; s.carry = carry;
    return s;
  endfunction

  function automatic stim_t mk_pop(input bit br, input bit tk, input logic [31:0] tgt, input bit stall);
    stim_t s;
    s = idle();
    s.ev = 1'b1; s.br = br; s.tk = tk; s.tgt = tgt; s.stall = stall;
    return s;
  endfunction

  // Apply one cycle of stimulus, advance the model, compare every output.
  task automatic step(input stim_t s);
    bit   full, eready, do_push, do_pop, missed;
    ent_t e;
    reset                     = s.rst;
    bus.fetch_valid           = s.fv;
    bus.fetch_PC4             = s.pc4;
    bus.fetch_p_dir           = s.pdir;
    bus.fetch_p_target        = s.ptgt;
    bus.fetch_bimodal         = s.bim;
    bus.fetch_carry           = s.carry;
    bus.execute_valid         = s.ev;
    bus.execute_is_branch     = s.br;
    bus.execute_taken         = s.tk;
    bus.execute_target        = s.tgt;
    bus.soin_bpredictor_stall = s.stall;
    #1;
    full   = (mq.size() == DEPTH);
    eready = (mq.size() != 0) && !(m_pend && s.stall);
    chk("fetch_ready", bus.fetch_ready, full ? 0 : 1);
    chk("execute_ready", bus.execute_ready, eready ? 1 : 0);
    @(posedge clk);
    if (s.rst) begin
      mq.delete();
      m_pend = 0; m_flush = 0; m_miss = 0; m_dir = 0; m_zero = 1;
      m_pc4 = 0; m_tgt = 0; m_redir = 0; m_bim = 0; m_carry = 0; m_be = 4'b0000;
    end else begin
      do_push = s.fv && !full;
      do_pop  = s.ev && eready;
      missed  = 0;
      m_flush = 0;
      if (do_pop) begin
        e = mq.pop_front();
        if (s.br) begin
          missed  = (e.pdir != s.tk) || (s.tk && e.pdir && e.ptgt != s.tgt);
          m_miss  = missed; m_dir = s.tk; m_pc4 = e.pc4; m_tgt = s.tgt;
          m_bim   = e.bim; m_carry = e.carry; m_be = s.tk ? 4'hF : 4'h1; m_zero = 0;
          if (missed) begin
            mq.delete();
            m_flush = 1;
            m_redir = s.tk ? s.tgt : e.pc4;
          end
        end
      end
      if (do_pop && s.br) m_pend = 1;
      else if (!s.stall)  m_pend = 0;
      if (do_push && !missed) mq.push_back('{s.pc4, s.pdir, s.ptgt, s.bim, s.carry});
    end
    #1;
    chk("update", bus.execute_bpredictor_update, m_pend ? 1 : 0);
    chk("flush", bus.resolve_flush, m_flush ? 1 : 0);
    if (m_flush || m_zero) chk("redirect_PC", bus.resolve_redirect_PC, m_redir);
    if (m_pend || m_zero) begin
      chk("upd_PC4", bus.execute_bpredictor_PC4, m_pc4);
      chk("upd_target", bus.execute_bpredictor_target, m_tgt);
      chk("upd_dir", bus.execute_bpredictor_dir, m_dir ? 1 : 0);
      chk("upd_miss", bus.execute_bpredictor_miss, m_miss ? 1 : 0);
      chk("upd_bimodal", bus.execute_bpredictor_bimodal, m_bim);
      chk("up_btb_data", bus.up_btb_data, m_tgt >> 2);
      chk("up_carry_data", bus.up_carry_data, m_carry);
      chk("byte_en", bus.byte_en, m_be);
    end
  endtask

  vec_t  vt[5];
  stim_t s;

  initial begin
    vt[0] = '{32'h104, 1, 32'h200, 12'h413, 1, 32'h200, 0, 1, 4'b1111, 0, 32'h0,   30'h80};
    vt[1] = '{32'h108, 1, 32'h180, 12'h021, 0, 32'h0,   1, 0, 4'b0001, 1, 32'h108, 30'h0};
    vt[2] = '{32'h10C, 1, 32'h300, 12'h0A2, 1, 32'h340, 1, 1, 4'b1111, 1, 32'h340, 30'hD0};
    vt[3] = '{32'h110, 0, 32'hDEAD, 12'h7F0, 0, 32'h0,  0, 0, 4'b0001, 0, 32'h0,   30'h0};
    vt[4] = '{32'h114, 0, 32'h0,   12'h553, 1, 32'h500, 1, 1, 4'b1111, 1, 32'h500, 30'h140};

    // power-on reset
    s = idle(); s.rst = 1;
    step(s);
    step(s);
    chk("rst_byte_en", bus.byte_en, 4'b0000);
    chk("rst_fetch_ready", bus.fetch_ready, 1);
    chk("rst_execute_ready", bus.execute_ready, 0);

    // directed single-branch resolutions
    for (int i = 0; i < 5; i++) begin
      step(mk_push(vt[i].pc4, vt[i].pdir, vt[i].ptgt, vt[i].bim, 9'(i * 37)));
      step(mk_pop(1, vt[i].tk, vt[i].tgt, 0));
      chk($sformatf("vec%0d_update", i), bus.execute_bpredictor_update, 1);
      chk($sformatf("vec%0d_miss", i), bus.execute_bpredictor_miss, vt[i].x_miss);
      chk($sformatf("vec%0d_dir", i), bus.execute_bpredictor_dir, vt[i].x_dir);
      chk($sformatf("vec%0d_byte_en", i), bus.byte_en, vt[i].x_be);
      chk($sformatf("vec%0d_flush", i), bus.resolve_flush, vt[i].x_flush);
      chk($sformatf("vec%0d_btb", i), bus.up_btb_data, vt[i].x_btb);
      chk($sformatf("vec%0d_bimodal", i), bus.execute_bpredictor_bimodal, vt[i].bim);
      if (vt[i].x_flush) chk($sformatf("vec%0d_redirect", i), bus.resolve_redirect_PC, vt[i].x_redir);
      step(idle());
      chk($sformatf("vec%0d_flush_clear", i), bus.resolve_flush, 0);
      chk($sformatf("vec%0d_upd_clear", i), bus.execute_bpredictor_update, 0);
      chk($sformatf("vec%0d_empty", i), bus.execute_ready, 0);
    end

    // full queue and simultaneous push+pop at full
    for (int i = 0; i < 4; i++) step(mk_push(32'h200 + 32'(4 * i), 0, 32'h0, 12'(i), 9'(i)));
    chk("full_fetch_ready", bus.fetch_ready, 0);
    s = mk_pop(0, 0, 32'h0, 0); s.fv = 1; s.pc4 = 32'h2F0;
    step(s);
    chk("overlap_occ3_ready", bus.fetch_ready, 1);
    step(mk_push(32'h2F4, 0, 32'h0, 12'h9, 9'h9));
    chk("refill_fetch_ready", bus.fetch_ready, 0);
    for (int i = 0; i < 4; i++) step(mk_pop(1, 0, 32'h0, 0));
    step(idle());
    chk("drained_exec_ready", bus.execute_ready, 0);

    // stall hold
    step(mk_push(32'h400, 1, 32'h800, 12'hABC, 9'h1FF));
    step(mk_push(32'h404, 0, 32'h0, 12'h001, 9'h002));
    step(mk_pop(1, 1, 32'h800, 1));
    for (int i = 0; i < 3; i++) begin
      step(mk_pop(1, 0, 32'h0, 1));
      chk("stall_update_held", bus.execute_bpredictor_update, 1);
      chk("stall_pc4_held", bus.execute_bpredictor_PC4, 32'h400);
      chk("stall_exec_ready", bus.execute_ready, 0);
    end
    s = idle();
    step(s);
    chk("stall_release_update", bus.execute_bpredictor_update, 0);
    step(mk_pop(1, 0, 32'h0, 0));

    // reset mid-flight: 3 entries queued and an update held
    for (int i = 0; i < 4; i++) step(mk_push(32'h600 + 32'(4 * i), 0, 32'h0, 12'h3, 9'h4));
    step(mk_pop(1, 1, 32'h700, 1));
    s = idle(); s.rst = 1; s.stall = 1;
    step(s);
    chk("mrst_update", bus.execute_bpredictor_update, 0);
    chk("mrst_flush", bus.resolve_flush, 0);
    chk("mrst_redirect", bus.resolve_redirect_PC, 0);
    chk("mrst_pc4", bus.execute_bpredictor_PC4, 0);
    chk("mrst_byte_en", bus.byte_en, 4'b0000);
    chk("mrst_fetch_ready", bus.fetch_ready, 1);
    chk("mrst_exec_ready", bus.execute_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step(idle());
      chk("post_rst_no_update", bus.execute_bpredictor_update, 0);
    end

    // random traffic against the queue model
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.fv    = $urandom_range(0, 2) != 0;
      s.pc4   = {$urandom_range(0, 16'hFFFF), 2'b00} + 32'h1000;
      s.pdir  = $urandom_range(0, 1);
      s.ptgt  = {$urandom_range(0, 16'hFFFF), 2'b00};
      s.bim   = 12'($urandom);
      s.carry = 9'($urandom);
      s.ev    = $urandom_range(0, 2) != 0;
      s.br    = $urandom_range(0, 3) != 0;
      s.tk    = $urandom_range(0, 1);
      s.stall = ($urandom_range(0, 3) == 0);
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        s.tk  = ($urandom_range(0, 3) != 0) ? mq[0].pdir : s.tk;
        s.tgt = mq[0].ptgt;
      end else begin
        s.tgt = {$urandom_range(0, 16'hFFFF), 2'b00};
      end
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
